// File: rtl/eld_pkg.sv
// Shared constants and types for the request debounce stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; the consumer samples levels on the changed strobe).
package eld_pkg;

    localparam int NCH                     = 3;
    localparam int CNT_W_DEF               = 16;
    localparam int DEBOUNCE_CYCLES_DEF     = 50000;

    typedef logic [NCH-1:0] req_t;

endpackage

// File: rtl/req_debounce3_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, mismatch counter, stable level.
// Latency: s1 capture at edge k -> stable_o updates at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running, upd_o is a combinational "updates this edge" strobe.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   btn_i    raw asynchronous input
//   stable_o registered debounced level
//   upd_o    high in the cycle whose closing edge loads a new stable level
module debounce_ch #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic stable_o,
    output logic upd_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synced input disagrees with the
    // stable level; any agreement (a bounce back) restarts it from zero.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd_o    = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            upd_o    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/req_debounce3.sv
// Three-channel request debouncer feeding the encoder gate; emits a changed strobe.
// Latency: s1 capture at edge k -> a/b/c, changed (and rise) update at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; changed is a one-cycle pulse the consumer must sample.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   btn_in   raw async requests, [2]->a, [1]->b, [0]->c
//   a,b,c    registered debounced levels
//   changed  one-cycle pulse coincident with any a/b/c update
//   rise     per-channel 0->1 pulse, only when built with EDGE_PULSE_EN; else 3'b000
module req_debounce3
    import eld_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] btn_in,
    output logic           a,
    output logic           b,
    output logic           c,
    output logic           changed,
    output logic [NCH-1:0] rise
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("req_debounce3: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    req_t stable;
    req_t upd;
    logic changed_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn_in[i]),
            .stable_o(stable[i]),
            .upd_o   (upd[i])
        );
    end

    // Registered on the same edge that loads the new levels, so the pulse
    // lines up with the fresh a/b/c values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |upd;
        end
    end

`ifdef EDGE_PULSE_EN
    req_t rise_q;

    // A channel that updates while its old level is 0 is going 0->1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= '0;
        end else begin
            rise_q <= upd & ~stable;
        end
    end

    assign rise = rise_q;
`else
    assign rise = '0;
`endif

    assign a       = stable[2];
    assign b       = stable[1];
    assign c       = stable[0];
    assign changed = changed_q;

endmodule

// File: tb/tb_req_debounce3.sv
// Bench for req_debounce3 with DEBOUNCE_CYCLES=4, CNT_W=4.
// Expected update events are queued at stimulus time and checked when due.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_req_debounce3;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_in;
    logic       a;
    logic       b;
    logic       c;
    logic       changed;
    logic [2:0] rise;

    typedef struct {
        int         cyc;
        logic [2:0] abc;
        logic [2:0] rs;
    } ev_t;

    ev_t sb[$];
    int  vectors;
    int  miscompares;
    int  cyc;

    req_debounce3 #(
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .a      (a),
        .b      (b),
        .c      (c),
        .changed(changed),
        .rise   (rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input driven after edge N is captured by s1 at N+1; the new level
    // appears at (N+1)+1+4 = N+6.
    task automatic push_ev(input int due, input logic [2:0] abc, input logic [2:0] rs);
        ev_t e;
        e.cyc = due;
        e.abc = abc;
`ifdef EDGE_PULSE_EN
        e.rs  = rs;
`else
        e.rs  = 3'b000;
`endif
        sb.push_back(e);
    endtask

    // Scoreboard: a due event must show a pulse with the queued levels;
    // any pulse with nothing due is unexpected.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_update: no changed pulse at cycle %0d, required abc=%b", sb[0].cyc, sb[0].abc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            vectors++;
            if (changed !== 1'b1 || {a, b, c} !== sb[0].abc || rise !== sb[0].rs) begin
                miscompares++;
                $display("FAIL update@%0d: changed=%b abc=%b rise=%b, required changed=1 abc=%b rise=%b",
                         cyc, changed, {a, b, c}, rise, sb[0].abc, sb[0].rs);
            end
            void'(sb.pop_front());
        end else if (changed === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_changed@%0d: changed=1 abc=%b rise=%b, required changed=0", cyc, {a, b, c}, rise);
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 3'b111;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({a, b, c, changed, rise} !== 7'b0) begin
                miscompares++;
                $display("FAIL reset: abc=%b changed=%b rise=%b, required all 0", {a, b, c}, changed, rise);
            end
        end
        btn_in = 3'b000;
        rst_n  = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if ({a, b, c} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: abc=%b, required 000", {a, b, c});
        end
    endtask

    task automatic test_single_rise();
        int n;
        btn_in = 3'b001;
        n = cyc;
        push_ev(n + 6, 3'b001, 3'b001);
        repeat (8) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                vectors++;
                if (c !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_early: c=%b at k+4, required 0", c);
                end
            end
            if (cyc == n + 6) begin
                vectors++;
                if (c !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_on_time: c=%b at k+5, required 1", c);
                end
            end
        end
    endtask

    task automatic test_fall();
        int n;
        btn_in = 3'b000;
        n = cyc;
        push_ev(n + 6, 3'b000, 3'b000);
        repeat (8) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                vectors++;
                if (c !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fall_early: c=%b at k+4, required 1", c);
                end
            end
        end
        vectors++;
        if (c !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_level: c=%b, required 0", c);
        end
    endtask

    task automatic test_glitch();
        int n;
        // Three captured highs reach cnt=3, one short of acceptance.
        btn_in = 3'b010;
        repeat (3) @(negedge clk);
        btn_in = 3'b000;
        repeat (8) begin
            @(negedge clk);
            vectors++;
            if (b !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch_reject: b=%b, required 0", b);
            end
        end
        // A cleared counter needs the full latency again.
        btn_in = 3'b010;
        n = cyc;
        push_ev(n + 6, 3'b010, 3'b010);
        repeat (8) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                vectors++;
                if (b !== 1'b0) begin
                    miscompares++;
                    $display("FAIL glitch_counter_cleared: b=%b at k+4, required 0", b);
                end
            end
        end
        btn_in = 3'b000;
        push_ev(cyc + 6, 3'b000, 3'b000);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int n;
        btn_in = 3'b110;
        n = cyc;
        push_ev(n + 6, 3'b110, 3'b110);
        repeat (8) @(negedge clk);
        vectors++;
        if ({a, b} !== 2'b11) begin
            miscompares++;
            $display("FAIL simultaneous_level: ab=%b, required 11", {a, b});
        end
        btn_in = 3'b000;
        push_ev(cyc + 6, 3'b000, 3'b000);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        btn_in = 3'b001;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({c, changed} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_clear: c=%b changed=%b, required 0 0", c, changed);
        end
        rst_n = 1'b1;
        n = cyc;
        push_ev(n + 6, 3'b001, 3'b001);
        repeat (8) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                vectors++;
                if (c !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid_partial: c=%b at k+4 after release, required 0", c);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int n;
        btn_in = 3'b100;
        @(negedge clk);
        btn_in = 3'b000;
        @(negedge clk);
        btn_in = 3'b100;
        n = cyc;
        push_ev(n + 6, 3'b100, 3'b100);
        repeat (8) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                vectors++;
                if (a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bounce_early: a=%b at k+4 of last run, required 0", a);
                end
            end
        end
        btn_in = 3'b000;
        push_ev(cyc + 6, 3'b000, 3'b000);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn_in      = 3'b000;
        test_reset();
        test_single_rise();
        test_fall();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_fall();
        test_bounce();
        repeat (4) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events: %0d left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
